// File: rtl/tfe_host_pkg.sv
// Shared types and constants for the TensorFlowE host-side link master.
package tfe_host_pkg;

  localparam int BYTES_OUT      = 4;
  localparam int BYTES_IN       = 2;
  localparam int IDX_W          = $clog2(BYTES_OUT);
  localparam int PULSE_W_DEF    = 4;
  localparam int WAIT_CYC_DEF   = 16;
  localparam int RD_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
`ifdef TFE_HOST_CLEAR_EN
    ST_CLEAR = 3'd3,
`endif
    ST_ACCU  = 3'd4,
    ST_READ  = 3'd5,
    ST_RESP  = 3'd6
  } state_t;

  // Outgoing byte order: A low, A high, B low, B high.
  function automatic logic [7:0] sel_byte(input logic [15:0] a, input logic [15:0] b,
                                          input logic [IDX_W-1:0] idx);
    logic [7:0] r;
    case (idx)
      2'd0:    r = a[7:0];
      2'd1:    r = a[15:8];
      2'd2:    r = b[7:0];
      default: r = b[15:8];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tfe_pulse_gen.sv
// One-shot strobe: PULSE_W cycles high then PULSE_W cycles low; done flags the last gap cycle.
module tfe_pulse_gen #(
  parameter int PULSE_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_pulse,
  output logic o_done
);

  localparam int CW = $clog2(2 * PULSE_W);
  localparam logic [CW-1:0] HI_CNT = CW'(PULSE_W);
  localparam logic [CW-1:0] LAST   = CW'(2 * PULSE_W - 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      // A start on the done cycle chains windows back to back.
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_busy && (r_cnt < HI_CNT);
  assign o_done  = r_busy && (r_cnt == LAST);

endmodule

// File: rtl/tfe_host_master.sv
// Host initiator for the TensorFlowE byte-strobe link: send A/B, clear/accumulate, read result.
// Optional clear phase enabled by defining TFE_HOST_CLEAR_EN.
module tfe_host_master
  import tfe_host_pkg::*;
#(
  parameter int PULSE_W    = PULSE_W_DEF,
  parameter int WAIT_CYC   = WAIT_CYC_DEF,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_clear,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic [7:0]  tfe_dat_o,
  output logic        tfe_wr_o,
  output logic        tfe_clear_o,
  output logic        tfe_accu_o,
  output logic        tfe_rd_o,
  input  logic [7:0]  tfe_dat_i,
  input  logic        tfe_vld_i
);

  localparam int WW = $clog2(WAIT_CYC + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [WW-1:0]    WAIT_LAST = WW'(WAIT_CYC - 1);
  localparam logic [TW-1:0]    TO_LAST   = TW'(RD_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] OUT_LAST  = IDX_W'(BYTES_OUT - 1);
  localparam logic [IDX_W-1:0] IN_LAST   = IDX_W'(BYTES_IN - 1);

  state_t           r_state, w_nxt;
  logic             w_start, w_pulse, w_pdone;
  logic [15:0]      r_a, r_b;
  logic [IDX_W-1:0] r_idx;
  logic [WW-1:0]    r_wcnt;
  logic [TW-1:0]    r_tcnt;
  logic             r_got, r_gap, r_cmd_ready, r_rsp_to;
  logic [15:0]      r_rsp_data;
  logic             w_hs, w_have, w_gap, w_tout, w_rd_adv;

`ifdef TFE_HOST_CLEAR_EN
  logic r_clr;
`else
  logic w_unused_clr;
  assign w_unused_clr = cmd_clear;
`endif

  assign w_hs     = cmd_valid && r_cmd_ready && (r_state == ST_IDLE);
  assign w_have   = r_got || tfe_vld_i;
  assign w_gap    = w_pdone || r_gap;
  assign w_tout   = (r_state == ST_READ) && !w_have && (r_tcnt == TO_LAST);
  assign w_rd_adv = (r_state == ST_READ) && w_gap && w_have;

  tfe_pulse_gen #(.PULSE_W(PULSE_W)) u_pulse (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .o_pulse (w_pulse),
    .o_done  (w_pdone)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  // w_start is raised one cycle ahead so each strobe rises on the first cycle of its phase.
  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE: if (w_hs) begin
        w_nxt   = ST_SEND;
        w_start = 1'b1;
      end
      ST_SEND: if (w_pdone) begin
        if (r_idx == OUT_LAST) w_nxt = ST_WAIT;
        else                   w_start = 1'b1;
      end
      ST_WAIT: if (r_wcnt == WAIT_LAST) begin
        w_start = 1'b1;
`ifdef TFE_HOST_CLEAR_EN
        w_nxt   = r_clr ? ST_CLEAR : ST_ACCU;
`else
        w_nxt   = ST_ACCU;
`endif
      end
`ifdef TFE_HOST_CLEAR_EN
      ST_CLEAR: if (w_pdone) begin
        w_nxt   = ST_ACCU;
        w_start = 1'b1;
      end
`endif
      ST_ACCU: if (w_pdone) begin
        w_nxt   = ST_READ;
        w_start = 1'b1;
      end
      ST_READ: begin
        if (w_tout) w_nxt = ST_RESP;
        else if (w_rd_adv) begin
          if (r_idx == IN_LAST) w_nxt = ST_RESP;
          else                  w_start = 1'b1;
        end
      end
      ST_RESP: if (rsp_ready) w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_idx <= '0; r_wcnt <= '0; r_tcnt <= '0;
      r_got <= 1'b0; r_gap <= 1'b0; r_cmd_ready <= 1'b0;
      r_rsp_data <= '0; r_rsp_to <= 1'b0;
`ifdef TFE_HOST_CLEAR_EN
      r_clr <= 1'b0;
`endif
    end else begin
      r_cmd_ready <= (w_nxt == ST_IDLE);
      r_wcnt      <= (r_state == ST_WAIT) ? r_wcnt + 1'b1 : '0;
      if (w_hs) begin
        r_a        <= cmd_a;
        r_b        <= cmd_b;
        r_idx      <= '0;
        r_rsp_data <= '0;
        r_rsp_to   <= 1'b0;
`ifdef TFE_HOST_CLEAR_EN
        r_clr      <= cmd_clear;
`endif
      end
      if (r_state == ST_SEND && w_pdone && r_idx != OUT_LAST) r_idx <= r_idx + 1'b1;
      if (r_state == ST_ACCU) r_idx <= '0;
      if (r_state == ST_READ) begin
        r_tcnt <= r_tcnt + 1'b1;
        if (w_pdone) r_gap <= 1'b1;
        // First valid of the byte wins, whether it lands in the high or low phase.
        if (tfe_vld_i && !r_got) begin
          r_got <= 1'b1;
          if (r_idx == '0) r_rsp_data[7:0]  <= tfe_dat_i;
          else             r_rsp_data[15:8] <= tfe_dat_i;
        end
        if (w_tout) begin
          r_rsp_data <= '0;
          r_rsp_to   <= 1'b1;
        end
        if (w_rd_adv && r_idx != IN_LAST) r_idx <= r_idx + 1'b1;
      end
      if (w_start) begin
        r_tcnt <= '0;
        r_got  <= 1'b0;
        r_gap  <= 1'b0;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_to;
  assign tfe_dat_o   = (r_state == ST_SEND) ? sel_byte(r_a, r_b, r_idx) : 8'h00;
  assign tfe_wr_o    = w_pulse && (r_state == ST_SEND);
  assign tfe_accu_o  = w_pulse && (r_state == ST_ACCU);
  assign tfe_rd_o    = w_pulse && (r_state == ST_READ);
`ifdef TFE_HOST_CLEAR_EN
  assign tfe_clear_o = w_pulse && (r_state == ST_CLEAR);
`else
  assign tfe_clear_o = 1'b0;
`endif

endmodule

// File: tb/tb_tfe_host_master.sv
// Bench for tfe_host_master: vector table, randomized commands, responder and strobe monitor.
module tb_tfe_host_master;

  localparam int PW   = 4;
  localparam int WC   = 16;
  localparam int RDTO = 255;
`ifdef TFE_HOST_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] a, b;
    logic        clr;
    logic [7:0]  b0, b1;
    int          d0, d1, glitch;   // responder delays (-1 = never), WAIT-phase glitch offset
    logic [15:0] exp_data;
    logic        exp_to;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_clear = 1'b0, rsp_ready = 1'b0;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic cmd_ready, rsp_valid, rsp_timeout, tfe_wr_o, tfe_clear_o, tfe_accu_o, tfe_rd_o;
  logic [15:0] rsp_data;
  logic [7:0] tfe_dat_o;
  logic [7:0] tfe_dat_i = '0;
  logic tfe_vld_i = 1'b0;

  tfe_host_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_clear(cmd_clear),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .tfe_dat_o(tfe_dat_o), .tfe_wr_o(tfe_wr_o),
    .tfe_clear_o(tfe_clear_o), .tfe_accu_o(tfe_accu_o), .tfe_rd_o(tfe_rd_o),
    .tfe_dat_i(tfe_dat_i), .tfe_vld_i(tfe_vld_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  // Stimulus side sets these; the monitor/responder only reads them.
  int seq = 0, hs_cyc = 0, glitch_off = -1;
  logic [7:0] rbyte[2];
  int rdly[2];

  // Monitor/responder state, written only by the negedge process.
  int seen = 0, wr_n, cur_hi, clr_n, acc_n, clr_first, acc_first, rd_first;
  int onehot_err, stab_err, ridx, pend, cnt;
  logic [7:0] wr_b[8], cur_b, p_dat;
  int wr_rc[8], wr_hl[8];
  logic p_wr, p_clr, p_acc, p_rd;

  always @(negedge clk) begin
    if (seq != seen) begin
      seen = seq; wr_n = 0; cur_hi = 0; clr_n = 0; acc_n = 0;
      clr_first = -1; acc_first = -1; rd_first = -1; onehot_err = 0; stab_err = 0;
      ridx = 0; pend = 0; cnt = 0; cur_b = '0;
      tfe_vld_i = 1'b0; tfe_dat_i = '0;
    end else begin
      if (tfe_wr_o && !p_wr) begin
        if (wr_n < 8) begin wr_b[wr_n] = tfe_dat_o; wr_rc[wr_n] = cyc; end
        wr_n++; cur_hi = 1; cur_b = tfe_dat_o;
      end else if (tfe_wr_o) cur_hi++;
      if (!tfe_wr_o && p_wr && wr_n > 0 && wr_n <= 8) wr_hl[wr_n-1] = cur_hi;
      if (tfe_wr_o && tfe_dat_o !== cur_b) stab_err++;
      if (!tfe_wr_o && tfe_dat_o !== p_dat && tfe_dat_o !== 8'h00) stab_err++;
      if (int'(tfe_wr_o) + int'(tfe_clear_o) + int'(tfe_accu_o) + int'(tfe_rd_o) > 1) onehot_err++;
      if (tfe_clear_o && !p_clr) begin clr_n++; if (clr_first < 0) clr_first = cyc; end
      if (tfe_accu_o && !p_acc) begin acc_n++; if (acc_first < 0) acc_first = cyc; end
      if (tfe_rd_o && !p_rd && rd_first < 0) rd_first = cyc;
      tfe_vld_i = 1'b0; tfe_dat_i = '0;
      if (tfe_rd_o && !p_rd && ridx < 2 && rdly[ridx] >= 0) begin pend = 1; cnt = rdly[ridx]; end
      if (pend != 0) begin
        if (cnt == 0) begin
          tfe_vld_i = 1'b1; tfe_dat_i = rbyte[ridx]; ridx++; pend = 0;
        end else cnt--;
      end
      if (glitch_off >= 0 && cyc == hs_cyc + glitch_off) begin
        tfe_vld_i = 1'b1; tfe_dat_i = 8'hFF;
      end
    end
    p_wr = tfe_wr_o; p_clr = tfe_clear_o; p_acc = tfe_accu_o; p_rd = tfe_rd_o; p_dat = tfe_dat_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: phase lengths straight from the protocol description.
  function automatic int byte_time(input int d);
    return (d + 1 > 2 * PW) ? d + 1 : 2 * PW;
  endfunction

  function automatic int model_lat(input vec_t v);
    int base = 1 + 8 * PW + WC + ((v.clr && CLR_EN) ? 2 * PW : 0) + 2 * PW;
    if (v.d0 < 0) return base + RDTO;
    if (v.d1 < 0) return base + byte_time(v.d0) + RDTO;
    return base + byte_time(v.d0) + byte_time(v.d1);
  endfunction

  task automatic prep(input vec_t v);
    rbyte[0] = v.b0; rbyte[1] = v.b1; rdly[0] = v.d0; rdly[1] = v.d1;
    glitch_off = -1; seq++;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic issue(input string nm, input vec_t v);
    int n = 0;
    cmd_a = v.a; cmd_b = v.b; cmd_clear = v.clr; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_accept"}, n < 50, 1);
    hs_cyc = cyc; glitch_off = v.glitch;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int id, input vec_t v, input int hold);
    string nm = $sformatf("v%0d", id);
    int n = 0, bad = 0, rsp_cyc, wr_snap;
    prep(v);
    issue(nm, v);
    while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
    chk({nm, "_rsp_valid"}, rsp_valid, 1);
    rsp_cyc = cyc;
    chk({nm, "_data"}, rsp_data, v.exp_data);
    chk({nm, "_timeout"}, rsp_timeout, v.exp_to);
    chk({nm, "_latency"}, rsp_cyc - hs_cyc, model_lat(v));
    chk({nm, "_wr_count"}, wr_n, 4);
    chk({nm, "_wr_bytes"}, {wr_b[0], wr_b[1], wr_b[2], wr_b[3]},
        {v.a[7:0], v.a[15:8], v.b[7:0], v.b[15:8]});
    for (int k = 0; k < 4; k++) begin
      if (wr_hl[k] != PW) bad++;
      if (k > 0 && wr_rc[k] - wr_rc[k-1] != 2 * PW) bad++;
    end
    chk({nm, "_wr_shape"}, bad, 0);
    chk({nm, "_wr_first"}, wr_rc[0] - hs_cyc, 1);
    chk({nm, "_clr_count"}, clr_n, (v.clr && CLR_EN) ? 1 : 0);
    chk({nm, "_acc_count"}, acc_n, 1);
    if (clr_n > 0) chk({nm, "_clr_before_acc"}, clr_first < acc_first, 1);
    if (v.d0 < 0) chk({nm, "_rd_to_rsp"}, rsp_cyc - rd_first, RDTO);
    chk({nm, "_onehot"}, onehot_err, 0);
    chk({nm, "_dat_stable"}, stab_err, 0);
    if (hold > 0) begin
      bad = 0; wr_snap = wr_n;
      cmd_a = 16'hDEAD; cmd_b = 16'hBEEF; cmd_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== v.exp_data || rsp_timeout !== v.exp_to || cmd_ready) bad++;
      end
      cmd_valid = 1'b0;
      chk({nm, "_hold_stable"}, bad, 0);
      chk({nm, "_hold_no_send"}, wr_n, wr_snap);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_rsp_drop"}, rsp_valid, 0);
    chk({nm, "_ready_back"}, cmd_ready, 1);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    tbl[0] = '{16'h0302, 16'h0504, 1'b0, 8'h1A, 8'h00, 0, 0, -1, 16'h001A, 1'b0};
    tbl[1] = '{16'hBEEF, 16'h1234, 1'b1, 8'h55, 8'hAA, 2, 3, -1, 16'hAA55, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b0, 8'hC3, 8'h3C, 9, 12, -1, 16'h3CC3, 1'b0};
    tbl[3] = '{16'h1111, 16'h2222, 1'b0, 8'h77, 8'h88, 1, 5, 40, 16'h8877, 1'b0};
    tbl[4] = '{16'h0A0B, 16'h0C0D, 1'b0, 8'h99, 8'h66, -1, -1, -1, 16'h0000, 1'b1};
    tbl[5] = '{16'h4321, 16'h8765, 1'b1, 8'h5A, 8'hA5, 3, -1, -1, 16'h0000, 1'b1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_timeout, tfe_dat_o,
                          tfe_wr_o, tfe_clear_o, tfe_accu_o, tfe_rd_o}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i], 0);

    for (int i = 0; i < 6; i++) begin
      rv.a = 16'($urandom); rv.b = 16'($urandom); rv.clr = 1'($urandom_range(0, 1));
      rv.b0 = 8'($urandom); rv.b1 = 8'($urandom);
      rv.d0 = int'($urandom_range(0, 12)); rv.d1 = int'($urandom_range(0, 12));
      rv.glitch = int'($urandom_range(34, 47));
      rv.exp_data = {rv.b1, rv.b0}; rv.exp_to = 1'b0;
      run_vec(10 + i, rv, 0);
    end

    run_vec(20, tbl[1], 20);

    // Reset in the middle of the third outgoing byte.
    begin
      int n = 0;
      prep(tbl[0]);
      issue("midrst", tbl[0]);
      while (wr_n < 3 && n < 100) begin @(negedge clk); n++; end
      chk("midrst_third_byte", wr_n, 3);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_timeout, tfe_dat_o,
                             tfe_wr_o, tfe_clear_o, tfe_accu_o, tfe_rd_o}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    rv = '{16'hA1B2, 16'hC3D4, 1'b0, 8'h3E, 8'h7F, 0, 4, -1, 16'h7F3E, 1'b0};
    run_vec(30, rv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
